// File: rtl/icache_refill_ctrl_if.sv
// Bundle between the icache refill sequencer, the icache lines, the core fetch port and the memory arbiter.
// Signal prefixes follow the controller's view: i_ signals are driven into it, o_ signals are driven by it.
interface icache_refill_ctrl_if #(
    parameter int unsigned DATABITS = 32,
    parameter int unsigned ADDRBITS = 32,
    parameter int unsigned BANKNUM  = 4,
    parameter int unsigned TTLBITS  = 8
);
    logic [ADDRBITS-1:0]        i_icache_addr;
    logic                       i_icache_rdreq;
    logic [BANKNUM-1:0]         i_line_miss;
    logic [BANKNUM*TTLBITS-1:0] i_line_ttl;
    logic [DATABITS-1:0]        i_mem_data;
    logic                       i_mem_valid;
    logic [BANKNUM-1:0]         o_flush_mode;
    logic                       o_flush_we;
    logic [ADDRBITS-1:0]        o_flush_addr;
    logic [DATABITS-1:0]        o_flush_in;
    logic                       o_mem_rdreq;
    logic [ADDRBITS-1:0]        o_mem_addr;
    logic                       o_busy;

    modport master (
        input  i_icache_addr, i_icache_rdreq, i_line_miss, i_line_ttl, i_mem_data, i_mem_valid,
        output o_flush_mode, o_flush_we, o_flush_addr, o_flush_in, o_mem_rdreq, o_mem_addr, o_busy
    );

    modport slave (
        output i_icache_addr, i_icache_rdreq, i_line_miss, i_line_ttl, i_mem_data, i_mem_valid,
        input  o_flush_mode, o_flush_we, o_flush_addr, o_flush_in, o_mem_rdreq, o_mem_addr, o_busy
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache refill sequencer: on a miss in every line, evicts the highest-TTL line and burst-refills it.
// Define ICACHE_CRITICAL_WORD_FIRST_EN to start the burst at the missed word instead of word 0.
module icache_refill_ctrl #(
    parameter int unsigned DATABITS      = 32,
    parameter int unsigned ADDRBITS      = 32,
    parameter int unsigned CACHEADDRBITS = 5,
    parameter int unsigned BANKNUM       = 4,
    parameter int unsigned TTLBITS       = 8
) (
    input logic                 i_clk,
    input logic                 i_reset,
    icache_refill_ctrl_if.master bus
);
    localparam int unsigned SecBits = ADDRBITS - CACHEADDRBITS - 2;
    localparam int unsigned VicBits = (BANKNUM > 1) ? $clog2(BANKNUM) : 1;
    localparam int unsigned CntW    = CACHEADDRBITS + 1;

    typedef enum logic [1:0] {StIdle, StSelect, StFetch, StDone} state_e;

    state_e                   r_state;
    logic [SecBits-1:0]       r_section;
    logic [CACHEADDRBITS-1:0] r_w;
    logic [CntW-1:0]          r_cnt;
    logic [BANKNUM-1:0]       r_flush_mode;
    logic                     r_flush_we;
    logic [ADDRBITS-1:0]      r_flush_addr;
    logic [DATABITS-1:0]      r_flush_in;
    logic                     r_mem_rdreq;
    logic [ADDRBITS-1:0]      r_mem_addr;
    logic                     r_busy;

    logic [CACHEADDRBITS-1:0] w_w0;
    logic [VicBits-1:0]       w_victim;
    logic [TTLBITS-1:0]       w_max;
    logic [BANKNUM-1:0]       w_onehot;
    logic [ADDRBITS-1:0]      w_word_addr;
    logic                     w_unused_addr;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign w_w0          = bus.i_icache_addr[CACHEADDRBITS+1:2];
    assign w_unused_addr = ^bus.i_icache_addr[1:0];
`else
    assign w_w0          = '0;
    assign w_unused_addr = ^bus.i_icache_addr[CACHEADDRBITS+1:0];
`endif

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        w_victim = '0;
        w_max    = bus.i_line_ttl[0 +: TTLBITS];
        for (int i = 1; i < BANKNUM; i++) begin
            if (bus.i_line_ttl[i*TTLBITS +: TTLBITS] > w_max) begin
                w_max    = bus.i_line_ttl[i*TTLBITS +: TTLBITS];
                w_victim = VicBits'(i);
            end
        end
    end

    assign w_onehot    = BANKNUM'(1) << w_victim;
    // Concatenation keeps the word offset from ever carrying into the section bits.
    assign w_word_addr = {r_section, r_w, 2'b00};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_section    <= '0;
            r_w          <= '0;
            r_cnt        <= '0;
            r_flush_mode <= '0;
            r_flush_we   <= 1'b0;
            r_flush_addr <= '0;
            r_flush_in   <= '0;
            r_mem_rdreq  <= 1'b0;
            r_mem_addr   <= '0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (bus.i_icache_rdreq && (&bus.i_line_miss)) begin
                        r_section <= bus.i_icache_addr[ADDRBITS-1:CACHEADDRBITS+2];
                        r_w       <= w_w0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= StSelect;
                    end
                end
                StSelect: begin
                    r_flush_mode <= w_onehot;
                    r_mem_rdreq  <= 1'b1;
                    r_mem_addr   <= w_word_addr;
                    r_state      <= StFetch;
                end
                StFetch: begin
                    if (r_mem_rdreq) begin
                        if (bus.i_mem_valid) begin
                            r_mem_rdreq  <= 1'b0;
                            r_flush_we   <= 1'b1;
                            r_flush_addr <= r_mem_addr;
                            r_flush_in   <= bus.i_mem_data;
                            r_w          <= r_w + CACHEADDRBITS'(1);
                            r_cnt        <= r_cnt + CntW'(1);
                        end
                    end else begin
                        // Write-pulse cycle: either re-request the next word or finish.
                        r_flush_we <= 1'b0;
                        if (r_cnt[CACHEADDRBITS]) begin
                            r_state <= StDone;
                        end else begin
                            r_mem_rdreq <= 1'b1;
                            r_mem_addr  <= w_word_addr;
                        end
                    end
                end
                StDone: begin
                    r_flush_mode <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.o_flush_mode = r_flush_mode;
    assign bus.o_flush_we   = r_flush_we;
    assign bus.o_flush_addr = r_flush_addr;
    assign bus.o_flush_in   = r_flush_in;
    assign bus.o_mem_rdreq  = r_mem_rdreq;
    assign bus.o_mem_addr   = r_mem_addr;
    assign bus.o_busy       = r_busy;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl with 4-word lines: a randomized memory responder, a flush-write
// recorder and a line-level reference model of victim choice, burst order and refill timing.
module tb_icache_refill_ctrl;
    localparam int CAB = 2;
    localparam int N   = 1 << CAB;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } fl_t;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   resp_min = 0;
    int   resp_max = 0;
    bit   spur_en  = 1'b0;
    int   overlap_err = 0;
    fl_t  fl_q[$];

    icache_refill_ctrl_if #(.DATABITS(32), .ADDRBITS(32), .BANKNUM(4), .TTLBITS(8)) bus ();

    icache_refill_ctrl #(
        .DATABITS(32), .ADDRBITS(32), .CACHEADDRBITS(CAB), .BANKNUM(4), .TTLBITS(8)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_flush_mode"}, 64'(bus.o_flush_mode), 64'h0);
        chk({tag, "_flush_we"}, 64'(bus.o_flush_we), 64'h0);
        chk({tag, "_flush_addr"}, 64'(bus.o_flush_addr), 64'h0);
        chk({tag, "_flush_in"}, 64'(bus.o_flush_in), 64'h0);
        chk({tag, "_mem_rdreq"}, 64'(bus.o_mem_rdreq), 64'h0);
        chk({tag, "_mem_addr"}, 64'(bus.o_mem_addr), 64'h0);
        chk({tag, "_busy"}, 64'(bus.o_busy), 64'h0);
    endtask

    // Memory: one valid pulse per request after a random delay; spurious pulses when idle.
    initial begin
        int d;
        bus.i_mem_valid = 1'b0;
        bus.i_mem_data  = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.o_mem_rdreq) begin
                d = $urandom_range(resp_max, resp_min);
                repeat (d) begin @(posedge clk); #1; end
                if (bus.o_mem_rdreq) begin
                    bus.i_mem_valid = 1'b1;
                    bus.i_mem_data  = mem_word(bus.o_mem_addr);
                    @(posedge clk); #1;
                    bus.i_mem_valid = 1'b0;
                end
            end else if (spur_en && ($urandom_range(3, 0) == 0)) begin
                bus.i_mem_valid = 1'b1;
                bus.i_mem_data  = $urandom;
                @(posedge clk); #1;
                bus.i_mem_valid = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (bus.o_flush_we) fl_q.push_back('{a: bus.o_flush_addr, d: bus.o_flush_in, m: bus.o_flush_mode});
        if (!$onehot0(bus.o_flush_mode)) overlap_err++;
    end

    // One full refill checked against the line model. 'started' means the DUT already left IDLE.
    task automatic refill(input logic [31:0] addr, input logic [7:0] t0, input logic [7:0] t1,
                          input logic [7:0] t2, input logic [7:0] t3, input int dmin,
                          input int dmax, input bit spur, input bit keep, input bit started);
        logic [7:0]  ttl[4];
        logic [31:0] base, ea;
        int vic, w0, cnt;
        bit done;
        ttl[0] = t0; ttl[1] = t1; ttl[2] = t2; ttl[3] = t3;
        vic = 0;
        for (int i = 1; i < 4; i++) if (ttl[i] > ttl[vic]) vic = i;
        base = {addr[31:4], 4'h0};
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        w0 = int'(addr[3:2]);
`else
        w0 = 0;
`endif
        resp_min = dmin;
        resp_max = dmax;
        spur_en  = spur;
        fl_q.delete();
        if (!started) begin
            @(negedge clk);
            bus.i_icache_addr  = addr;
            bus.i_line_ttl     = {t3, t2, t1, t0};
            bus.i_line_miss    = 4'hF;
            bus.i_icache_rdreq = 1'b1;
        end
        cnt  = started ? 1 : 0;
        done = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            @(negedge clk);
            if (bus.o_busy) cnt++;
            else if (cnt > 0) done = 1'b1;
        end
        chk("refill_done", 64'(done), 64'h1);
        if (!keep) begin
            bus.i_icache_rdreq = 1'b0;
            bus.i_line_miss    = 4'hF & ~(4'h1 << vic);
        end
        chk("fill_count", 64'(fl_q.size()), 64'(N));
        for (int k = 0; k < N; k++) begin
            if (k < fl_q.size()) begin
                ea = base + 32'(4 * ((w0 + k) % N));
                chk("fill_addr", 64'(fl_q[k].a), 64'(ea));
                chk("fill_data", 64'(fl_q[k].d), 64'(mem_word(ea)));
                chk("fill_mode", 64'(fl_q[k].m), 64'(4'h1 << vic));
            end
        end
        if (dmin == dmax) chk("busy_cycles", 64'(cnt), 64'((2 + dmin) * N + 2));
    endtask

    initial begin
        bit seen;
        reset              = 1'b1;
        bus.i_icache_addr  = '0;
        bus.i_icache_rdreq = 1'b0;
        bus.i_line_miss    = '0;
        bus.i_line_ttl     = '0;
        repeat (3) @(negedge clk);
        chk_quiet("in_reset");
        reset = 1'b0;
        @(negedge clk);
        chk_quiet("after_reset");

        // Tie between lines 1 and 2 resolves to line 1.
        refill(32'h0000_1008, 8'd5, 8'd9, 8'd9, 8'd1, 1, 1, 1'b0, 1'b0, 1'b0);
        refill(32'h0000_2C04, 8'd3, 8'd2, 8'd7, 8'd1, 0, 0, 1'b0, 1'b0, 1'b0);

        // Partial miss must never start a refill.
        @(negedge clk);
        bus.i_icache_addr  = 32'h0000_3000;
        bus.i_line_miss    = 4'b1011;
        bus.i_icache_rdreq = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.o_busy || bus.o_mem_rdreq) seen = 1'b1;
        end
        chk("partial_miss_idle", 64'(seen), 64'h0);
        bus.i_icache_rdreq = 1'b0;

        refill(32'h0000_4000, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 0, 3, 1'b0, 1'b0, 1'b0);
        refill(32'h0000_5004, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 3, 1'b0, 1'b0, 1'b0);

        // Miss held through DONE: exactly one IDLE cycle, then a fresh refill.
        refill(32'h0000_600C, 8'd1, 8'd2, 8'd3, 8'd4, 0, 2, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("restart_after_idle", 64'(bus.o_busy), 64'h1);
        refill(32'h0000_600C, 8'd1, 8'd2, 8'd3, 8'd4, 0, 2, 1'b0, 1'b0, 1'b1);

        // Reset mid-fetch aborts immediately.
        @(negedge clk);
        resp_min = 3; resp_max = 3;
        bus.i_icache_addr  = 32'h0000_7000;
        bus.i_line_ttl     = {8'd1, 8'd1, 8'd1, 8'd1};
        bus.i_line_miss    = 4'hF;
        bus.i_icache_rdreq = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (bus.o_mem_rdreq) seen = 1'b1;
        end
        chk("fetch_reached", 64'(seen), 64'h1);
        reset = 1'b1;
        @(negedge clk);
        chk_quiet("mid_reset");
        bus.i_icache_rdreq = 1'b0;
        bus.i_line_miss    = 4'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fl_q.delete();
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.o_busy) seen = 1'b1;
        end
        chk("post_reset_no_write", 64'(fl_q.size()), 64'h0);
        chk("post_reset_idle", 64'(seen), 64'h0);

        for (int r = 0; r < 6; r++) begin
            refill($urandom, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 0, 7,
                   1'b1, 1'b0, 1'b0);
        end

        chk("mode_overlap", 64'(overlap_err), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
